// File: rtl/gray_pkg.sv
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared types and helpers for the Gray<->binary converter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

    typedef enum logic {
        MODE_G2B = 1'b0,
        MODE_B2G = 1'b1
    } conv_mode_t;

    function automatic int chunk_w(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_xor_stage.sv
// ============================================================================
//  Module      : gray_xor_stage
//  Description : One pipeline stage; resolves its MSB-first chunk of the
//                prefix-XOR (Gray->binary) or forms the Gray code at stage 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_xor_stage
    import gray_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             in_valid,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_err,
    output logic             out_valid,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    localparam int c_chunk = chunk_w(WIDTH, STAGES);
    localparam int c_hi    = WIDTH - 1 - IDX * c_chunk;
    localparam int c_lo    = (c_hi - c_chunk + 1 < 0) ? 0 : (c_hi - c_chunk + 1);

    logic             w_carry;
    logic             w_acc;
    logic [WIDTH-1:0] w_res;

    // Bits above this chunk are already binary, so the carry is the lowest resolved bit.
    generate
        if (c_hi >= WIDTH - 1 || c_hi < 0) begin : g_carry_none
            assign w_carry = 1'b0;
        end else begin : g_carry_prev
            assign w_carry = in_data[c_hi+1];
        end
    endgenerate

    always_comb begin
        w_res = in_data;
        w_acc = w_carry;
        if (conv_mode_t'(in_mode) == MODE_B2G) begin
            if (IDX == 0) begin
                w_res = in_data ^ (in_data >> 1);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i <= c_hi && i >= c_lo) begin
                    w_acc    = w_acc ^ in_data[i];
                    w_res[i] = w_acc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_data  <= w_res;
            out_err   <= in_err;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gray_bin_conv_pipe.sv
// ============================================================================
//  Module      : gray_bin_conv_pipe
//  Description : Pipelined Gray<->binary converter with valid/ready handshake.
//                Optional Gray step checker enabled by GRAY_STEP_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_bin_conv_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic             step_err
);

    logic             w_adv;
    logic             w_err_in;
    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_mode;
    logic [STAGES:0]  w_err;
    logic [WIDTH-1:0] w_data [0:STAGES];

    // Whole pipe shifts as one; bubbles are kept so latency stays fixed.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    assign w_valid[0] = in_valid;
    assign w_mode[0]  = in_mode;
    assign w_data[0]  = in_data;
    assign w_err[0]   = w_err_in;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            gray_xor_stage #(
                .WIDTH  (WIDTH),
                .STAGES (STAGES),
                .IDX    (k)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .adv       (w_adv),
                .in_valid  (w_valid[k]),
                .in_mode   (w_mode[k]),
                .in_data   (w_data[k]),
                .in_err    (w_err[k]),
                .out_valid (w_valid[k+1]),
                .out_mode  (w_mode[k+1]),
                .out_data  (w_data[k+1]),
                .out_err   (w_err[k+1])
            );
        end
    endgenerate

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] r_prev;
    logic             r_have_prev;
    logic             w_is_g2b;

    assign w_is_g2b = (conv_mode_t'(in_mode) == MODE_G2B);
    assign w_err_in = r_have_prev & w_is_g2b &
                      (popcount(64'(in_data ^ r_prev)) != 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
        end else if (in_valid && w_adv && w_is_g2b) begin
            r_prev      <= in_data;
            r_have_prev <= 1'b1;
        end
    end
`else
    assign w_err_in = 1'b0;
`endif

    assign out_valid = w_valid[STAGES];
    assign out_mode  = w_mode[STAGES];
    assign out_data  = w_data[STAGES];
    assign step_err  = w_err[STAGES] & out_valid;

endmodule

`default_nettype wire

// File: tb/tb_gray_bin_conv_pipe.sv
// ============================================================================
//  Module      : tb_gray_bin_conv_pipe
//  Description : Self-checking bench for gray_bin_conv_pipe (4/2 main instance,
//                8-bit instances with 1, 3 and 8 stages).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_bin_conv_pipe;

    localparam int STG = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_mode;
    logic [3:0] out_data;
    logic       step_err;

    logic       sw_valid;
    logic [7:0] sw_data;
    logic       sw_mode = 1'b0;
    logic       sw_oready = 1'b1;
    logic       sw_ir [3];
    logic       sw_ov [3];
    logic       sw_om [3];
    logic [7:0] sw_od [3];
    logic       sw_se [3];
    logic       sw_check = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int stalls  = 0;

    typedef struct {
        logic       mode;
        logic [3:0] data;
        logic       err;
        int         acc_cyc;
        int         acc_stalls;
    } exp_t;

    typedef struct {
        logic       mode;
        logic [3:0] din;
        logic [3:0] dout;
    } vec_t;

    exp_t       sb[$];
    vec_t       tbl[35];
    logic [3:0] prev_g;
    logic       have_prev;
    logic       rnd_on;
    logic       hv [16];
    logic [7:0] hd [16];
    int         sw_st [3] = '{1, 3, 8};

    always #5 clk = ~clk;

    gray_bin_conv_pipe #(.WIDTH(4), .STAGES(STG)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
        .step_err(step_err)
    );

    gray_bin_conv_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_ir[0]),
        .in_mode(sw_mode), .in_data(sw_data), .out_valid(sw_ov[0]),
        .out_ready(sw_oready), .out_mode(sw_om[0]), .out_data(sw_od[0]),
        .step_err(sw_se[0])
    );

    gray_bin_conv_pipe #(.WIDTH(8), .STAGES(3)) dut_s3 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_ir[1]),
        .in_mode(sw_mode), .in_data(sw_data), .out_valid(sw_ov[1]),
        .out_ready(sw_oready), .out_mode(sw_om[1]), .out_data(sw_od[1]),
        .step_err(sw_se[1])
    );

    gray_bin_conv_pipe #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_ir[2]),
        .in_mode(sw_mode), .in_data(sw_data), .out_valid(sw_ov[2]),
        .out_ready(sw_oready), .out_mode(sw_om[2]), .out_data(sw_od[2]),
        .step_err(sw_se[2])
    );

    // Binary is the XOR of every right shift of the Gray code.
    function automatic logic [63:0] ref_g2b(input logic [63:0] g);
        logic [63:0] b;
        b = '0;
        for (int s = 0; s < 64; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [63:0] ref_b2g(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic send(input logic m, input logic [3:0] d, input logic [3:0] e);
        int   n;
        logic done;
        logic err;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                err = 1'b0;
                if (m == 1'b0) begin
                    err = have_prev && ($countones(d ^ prev_g) != 1);
                    prev_g = d;
                    have_prev = 1'b1;
                end
`ifndef GRAY_STEP_CHECK_EN
                err = 1'b0;
`endif
                sb.push_back('{m, e, err, cyc, stalls});
                done = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            if (!done && n > 50) begin
                fail("accept_timeout");
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) fail("drain");
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && out_valid && !out_ready) stalls <= stalls + 1;
    end

    // Scoreboard side: every visible result is checked against the queue head.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] t;
        int          k;
        if (reset) begin
            sb.delete();
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                fail("spurious_out_valid");
            end else begin
                e = sb[0];
                chk("out_data", out_data, e.data);
                chk("out_mode", out_mode, e.mode);
                chk("step_err", step_err, e.err);
                if (out_ready) begin
                    chk("latency", cyc - e.acc_cyc, STG + stalls - e.acc_stalls);
                    void'(sb.pop_front());
                end else begin
                    chk("in_ready_stall", in_ready, 1'b0);
                end
            end
        end
        hv[cyc % 16] = sw_valid;
        hd[cyc % 16] = sw_data;
        if (sw_check) begin
            for (int j = 0; j < 3; j++) begin
                k = (cyc - sw_st[j]) % 16;
                chk($sformatf("sweep_valid_s%0d", sw_st[j]), sw_ov[j], hv[k]);
                if (hv[k]) begin
                    t = ref_g2b({56'd0, hd[k]});
                    chk($sformatf("sweep_data_s%0d", sw_st[j]), sw_od[j], t[7:0]);
                end
            end
        end
    end

    initial begin
        logic [63:0] t;
        for (int i = 0; i < 16; i++) begin hv[i] = 1'b0; hd[i] = '0; end
        for (int i = 0; i < 16; i++) begin
            t = ref_g2b(64'(i));
            tbl[i] = '{1'b0, 4'(i), t[3:0]};
            t = ref_b2g(64'(i));
            tbl[16+i] = '{1'b1, 4'(i), t[3:0]};
        end
        tbl[32] = '{1'b0, 4'b1011, 4'b1101};
        tbl[33] = '{1'b0, 4'b1111, 4'b1010};
        tbl[34] = '{1'b1, 4'b1101, 4'b1011};

        reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
        out_ready = 1'b1; sw_valid = 1'b0; sw_data = '0;
        have_prev = 1'b0; prev_g = '0; rnd_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 4'b0);
        chk("rst_out_mode", out_mode, 1'b0);
        chk("rst_step_err", step_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;

        // Exhaustive plus hand-picked boundary values, back to back.
        for (int i = 0; i < 35; i++) send(tbl[i].mode, tbl[i].din, tbl[i].dout);
        drain();

        // Alternating-mode stream with a 3-cycle output stall in the middle.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    t = (i % 2 == 0) ? ref_g2b(64'(i + 3)) : ref_b2g(64'(i + 3));
                    send(1'(i % 2), 4'(i + 3), t[3:0]);
                end
            end
            begin
                repeat (4) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        send(1'b0, 4'b0110, 4'b0100);
        send(1'b1, 4'b0110, 4'b0101);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        have_prev = 1'b0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        send(1'b0, 4'b0000, 4'b0000);
        chk("postrst_lat1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("postrst_lat2_valid", out_valid, 1'b1);
        chk("postrst_lat2_data", out_data, 4'b0000);
        send(1'b0, 4'b0001, 4'b0001);
        send(1'b0, 4'b0011, 4'b0010);
        send(1'b0, 4'b0000, 4'b0000);
        drain();

        // Random mixed stream under random backpressure.
        rnd_on = 1'b1;
        fork
            begin
                logic       m;
                logic [3:0] d;
                for (int i = 0; i < 60; i++) begin
                    m = 1'($urandom_range(0, 1));
                    d = 4'($urandom_range(0, 15));
                    t = m ? ref_b2g(64'(d)) : ref_g2b(64'(d));
                    send(m, d, t[3:0]);
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Wider instances with uneven chunking, random Gray input.
        sw_check = 1'b1;
        for (int i = 0; i < 80; i++) begin
            sw_valid = ($urandom_range(0, 5) != 0);
            sw_data  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        sw_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        sw_check = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
